// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU / HI-LO block.
//   - op_sel encodings consumed from the ALU-control decoder
//   - alu_lo_hi result-source codes
//   - execute FSM state type
package alu_pkg;

    localparam logic [5:0] OP_SLL   = 6'h00;
    localparam logic [5:0] OP_SRL   = 6'h02;
    localparam logic [5:0] OP_SRA   = 6'h03;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_ADDU  = 6'h21;
    localparam logic [5:0] OP_SUBU  = 6'h23;
    localparam logic [5:0] OP_AND   = 6'h24;
    localparam logic [5:0] OP_OR    = 6'h25;
    localparam logic [5:0] OP_XOR   = 6'h26;
    localparam logic [5:0] OP_SLT   = 6'h2A;
    localparam logic [5:0] OP_SLTU  = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_LO  = 2'b01;
    localparam logic [1:0] SRC_HI  = 2'b10;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative LSB-first shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (aborts a multiply)
//   i_start      load operands and begin WIDTH iterations
//   i_signed     treat operands as two's complement (magnitudes + sign fixup)
//   i_a, i_b     operands
//   o_done       high during the final iteration; o_product is valid the cycle after
//   o_product    2*WIDTH product, sign-corrected, held until the next start
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_neg;

    logic [WIDTH:0]     w_a_mag;
    logic [WIDTH:0]     w_b_mag;
    logic               w_last;

    // Magnitudes are formed one bit wider so that -2^(WIDTH-1) negates exactly.
    assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? -{i_a[WIDTH-1], i_a} : {1'b0, i_a};
    assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? -{i_b[WIDTH-1], i_b} : {1'b0, i_b};

    assign w_last    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_done    = w_last;
    assign o_product = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{(WIDTH-1){1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_hilo_exec.sv
// Execute stage: single-cycle ALU, result-source mux, HI/LO registers and
// issue control for the iterative multiplier.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   issue handshake; in_ready drops while a multiply runs
//   op_sel              operation code (alu_pkg encodings)
//   hi_en, lo_en        HI/LO write enables applied when a multiply completes
//   alu_lo_hi           result source: ALU, LO or HI
//   a, b, shamt         operands and shift amount
//   out_valid, result   registered result, one pulse per accepted op
//   hi_q, lo_q          architectural HI/LO
module alu_hilo_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op_sel,
    input  logic             hi_en,
    input  logic             lo_en,
    input  logic [1:0]       alu_lo_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_out_valid;
    logic               r_hi_en;
    logic               r_lo_en;

    state_e             w_state_d;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_src;

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_mul_start = w_accept & is_mul_op(op_sel);

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_signed  (op_sel == OP_MULT),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_alu = '0;
        case (op_sel)
            OP_ADDU: w_alu = a + b;
            OP_SUBU: w_alu = a - b;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_SLL:  w_alu = b << shamt;
            OP_SRL:  w_alu = b >> shamt;
            OP_SRA:  w_alu = $signed(b) >>> shamt;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, a < b};
            default: w_alu = '0;
        endcase

        case (alu_lo_hi)
            SRC_LO:  w_src = r_lo;
            SRC_HI:  w_src = r_hi;
            default: w_src = w_alu;
        endcase

        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_d = MUL;
            MUL:     if (w_mul_done)  w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_hi_en     <= 1'b0;
            r_lo_en     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_out_valid <= 1'b0;
            if (w_mul_start) begin
                r_hi_en <= hi_en;
                r_lo_en <= lo_en;
            end else if (w_accept) begin
                r_result    <= w_src;
                r_out_valid <= 1'b1;
            end
            // Accept only happens in IDLE, so this never collides with the above.
            if (r_state == DONE) begin
                if (r_hi_en) r_hi <= w_product[2*WIDTH-1:WIDTH];
                if (r_lo_en) r_lo <= w_product[WIDTH-1:0];
                r_result    <= '0;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign hi_q      = r_hi;
    assign lo_q      = r_lo;

endmodule

// File: tb/tb_alu_hilo_exec.sv
// Directed bench for alu_hilo_exec with a result scoreboard.
module tb_alu_hilo_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  op_sel = '0;
    logic        hi_en = 1'b0;
    logic        lo_en = 1'b0;
    logic [1:0]  alu_lo_hi = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_hilo_exec #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .hi_en     (hi_en),
        .lo_en     (lo_en),
        .alu_lo_hi (alu_lo_hi),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .result    (result),
        .hi_q      (hi_q),
        .lo_q      (lo_q)
    );

    always #5 clk = ~clk;

    // Scoreboard: every out_valid pulse consumes the oldest expected result.
    always @(negedge clk) begin : sb
        logic [31:0] e;
        if (out_valid === 1'b1) begin
            pulses++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_out_valid: got result %h with nothing pending", result);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (result === e) else begin
                    errors++;
                    $error("FAIL result: got %h expected %h", result, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [4:0] sh, input logic [1:0] src, input logic [31:0] expv);
        @(negedge clk);
        in_valid  = 1'b1;
        op_sel    = op;
        a         = aa;
        b         = bb;
        shamt     = sh;
        alu_lo_hi = src;
        hi_en     = 1'b0;
        lo_en     = 1'b0;
        exp_q.push_back(expv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Issue a multiply, count stall cycles, then check HI/LO against the model.
    // With hold set, an MFHI-style read is presented during the stall.
    task automatic mul(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                       input logic he, input logic le, input logic hold);
        logic [63:0] p;
        int n;
        if (sgn) p = $signed({{32{aa[31]}}, aa}) * $signed({{32{bb[31]}}, bb});
        else     p = {32'b0, aa} * {32'b0, bb};
        @(negedge clk);
        in_valid  = 1'b1;
        op_sel    = sgn ? OP_MULT : OP_MULTU;
        a         = aa;
        b         = bb;
        hi_en     = he;
        lo_en     = le;
        alu_lo_hi = SRC_ALU;
        exp_q.push_back(32'h0);
        if (he) m_hi = p[63:32];
        if (le) m_lo = p[31:0];
        @(negedge clk);
        if (hold) begin
            op_sel    = OP_ADDU;
            a         = 32'd1;
            b         = 32'd1;
            alu_lo_hi = SRC_HI;
            hi_en     = 1'b0;
            lo_en     = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mul_stall_cycles", 32'(n), 32'd33);
        chk("mul_hi", hi_q, m_hi);
        chk("mul_lo", lo_q, m_lo);
        if (hold) exp_q.push_back(m_hi);
    endtask

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_hi", hi_q, 32'h0);
        chk("rst_lo", lo_q, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        rst_n = 1'b1;

        issue(OP_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, SRC_ALU, 32'h0);
        idle(1);
        chk("addu_out_valid", {31'b0, out_valid}, 32'h1);
        chk("addu_hi", hi_q, 32'h0);
        chk("addu_lo", lo_q, 32'h0);

        issue(OP_SRA,  32'h0, 32'h8000_0000, 5'd4, SRC_ALU, 32'hF800_0000);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, SRC_ALU, 32'h1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, SRC_ALU, 32'h0);
        issue(OP_SLL,  32'h0, 32'h1, 5'd31, SRC_ALU, 32'h8000_0000);
        issue(OP_HALT, 32'h5, 32'h6, 5'd0, SRC_ALU, 32'h0);
        issue(6'h3E,   32'h5, 32'h6, 5'd0, SRC_ALU, 32'h0);
        issue(OP_SRL,  32'h0, 32'h8000_0000, 5'd4, SRC_ALU, 32'h0800_0000);
        idle(3);
        chk("idle_out_valid", {31'b0, out_valid}, 32'h0);
        chk("idle_result_hold", result, 32'h0800_0000);

        mul(1'b0, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b1, 1'b0);
        issue(OP_ADDU, 32'h5, 32'h6, 5'd0, SRC_HI, m_hi);
        issue(OP_ADDU, 32'h5, 32'h6, 5'd0, SRC_LO, m_lo);
        issue(OP_ADDU, 32'h5, 32'h6, 5'd0, 2'b11, 32'd11);
        idle(2);

        mul(1'b1, 32'hFFFF_FFFD, 32'h7, 1'b1, 1'b1, 1'b0);
        mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        mul(1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0);
        mul(1'b1, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
        mul(1'b0, 32'h7, 32'h9, 1'b0, 1'b0, 1'b0);
        mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        idle(3);

        p0 = pulses;
        issue(OP_ADDU, 32'h1234_5678, 32'h1111_1111, 5'd0, SRC_ALU, 32'h2345_6789);
        issue(OP_SUBU, 32'h0, 32'h1, 5'd0, SRC_ALU, 32'hFFFF_FFFF);
        issue(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, SRC_ALU, 32'hF000_F000);
        issue(OP_OR,   32'hF0F0_F0F0, 32'h0F00_0F00, 5'd0, SRC_ALU, 32'hFFF0_FFF0);
        issue(OP_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 5'd0, SRC_ALU, 32'h5555_AAAA);
        idle(3);
        chk("b2b_pulses", 32'(pulses - p0), 32'd5);

        // Abort a multiply with reset partway through.
        @(negedge clk);
        in_valid = 1'b1;
        op_sel   = OP_MULT;
        a        = 32'h1234_5678;
        b        = 32'h9;
        hi_en    = 1'b1;
        lo_en    = 1'b1;
        idle(10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'h0);
        chk("abort_hi", hi_q, 32'h0);
        chk("abort_lo", lo_q, 32'h0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'h1);
        rst_n = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        idle(40);
        chk("abort_hi_after", hi_q, 32'h0);
        chk("abort_lo_after", lo_q, 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_hilo_exec.md
Name: alu_hilo_exec

Overview:
- Execute-stage consumer of the ALU-control decode outputs `op_sel`, `hi_en`, `lo_en` and `alu_lo_hi`.
- Performs the single-cycle ALU ops and owns the architectural HI/LO registers.
- Runs MULT/MULTU on an iterative shift-add multiplier and stalls issue while it is busy.
- Sits between the ID/EX pipeline register and the EX/MEM register; drives the result mux that feeds writeback.

Parameters:
- WIDTH, 32, operand/result width; multiply takes WIDTH iteration cycles; product is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  in  1  issue request; accepted when in_valid & in_ready
- in_ready  out  1  block can accept an op this cycle
- op_sel  in  6  operation code (encodings below)
- hi_en  in  1  write HI on multiply completion
- lo_en  in  1  write LO on multiply completion
- alu_lo_hi  in  2  result source: 00 ALU, 01 LO, 10 HI, 11 ALU
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate)
- shamt  in  5  shift amount
- out_valid  out  1  result valid, one-cycle pulse per accepted op
- result  out  WIDTH  registered result
- hi_q  out  WIDTH  current HI register
- lo_q  out  WIDTH  current LO register

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE.
  - `result`, `hi_q`, `lo_q`, `out_valid` = 0; `in_ready` = 1 from the first cycle after reset.
  - A multiply in flight is aborted; HI/LO are not written.
- op_sel encodings, defined in the package:
  - ADDU 0x21, SUBU 0x23, MULT 0x18, MULTU 0x19.
  - SLL 0x00, SRL 0x02, SRA 0x03.
  - SLT 0x2A, SLTU 0x2B.
  - AND 0x24, OR 0x25, XOR 0x26.
  - HALT 0x3F.
- Single-cycle ops, on accept in IDLE:
  - `result` and `out_valid` are registered next cycle (latency 1).
  - ADDU/SUBU: modulo 2^WIDTH, no overflow trap.
  - SLL/SRL/SRA shift `b` by `shamt`; SRA sign-fills.
  - SLT: signed compare a<b, result 1 or 0. SLTU: unsigned compare, result 1 or 0.
  - HALT and any undefined code: ALU result = 0.
- Result mux is applied after the ALU: `alu_lo_hi`=01 returns `lo_q`, 10 returns `hi_q`, otherwise the ALU result.
  - Ops may issue back-to-back every cycle; `in_ready` stays 1 in IDLE.
- MULT/MULTU:
  - On accept, capture operands, `hi_en` and `lo_en`; go to MUL; `in_ready` = 0.
  - MULT takes operand magnitudes and records the result sign = a[W-1]^b[W-1].
  - MUL: WIDTH iterations, one multiplier bit per cycle (LSB-first shift-add) into a 2*WIDTH accumulator; 5-bit iteration counter.
  - After the last iteration go to DONE. In DONE:
    - MULT with sign set: negate the product in two's complement.
    - Write HI = upper WIDTH bits if the captured `hi_en`=1; write LO = lower WIDTH bits if the captured `lo_en`=1.
    - Pulse `out_valid` with `result` = 0; return to IDLE.
  - Latency from accept to `out_valid` = WIDTH+1 cycles; `in_ready` returns to 1 in the cycle after DONE.
  - The next op may be accepted in that cycle and sees the updated HI/LO.
- States: IDLE -> MUL (accepted multiply); MUL -> MUL while count != WIDTH-1; MUL -> DONE; DONE -> IDLE.
- Boundary cases:
  - `in_valid`=0 in IDLE: `out_valid`=0 next cycle; `result` holds its value.
  - Inputs while `in_ready`=0 are ignored. Upstream holds them; no buffering.
  - Multiply with both captured enables = 0: full latency, no HI/LO write.
  - Operand 0x80000000 under MULT: magnitude computed in WIDTH+1 bits; must give the exact product.
  - An MFHI/MFLO-style read issued during a multiply stalls via `in_ready` until DONE completes.

Decomposition:
- Package `alu_pkg`: the op_sel localparams above; alu_lo_hi codes SRC_ALU, SRC_LO, SRC_HI; a state enum {IDLE, MUL, DONE}.
- One sub-module `seq_multiplier` (start/done handshake, signed flag, WIDTH param, 2*WIDTH product). The top-level holds the ALU, result mux, HI/LO registers and FSM.

Test Plan:
- Reset, then ADDU a=0xFFFFFFFF b=1 -> next cycle `result`=0, `out_valid`=1; `hi_q`=`lo_q`=0.
- SRA b=0x80000000 shamt=4 -> 0xF8000000. SLT a=-1 b=1 -> 1. SLTU same operands -> 0.
- MULTU a=0xFFFFFFFF b=2, `hi_en`=`lo_en`=1:
  - `in_ready`=0 for 33 cycles, then HI=1, LO=0xFFFFFFFE.
  - Then `alu_lo_hi`=10 -> `result`=1.
- MULT a=-3 b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> HI=0x40000000, LO=0.
- MULT with `hi_en`=1, `lo_en`=0 -> only HI changes. Assert `rst_n`=0 at cycle 10 of a multiply -> IDLE, HI/LO=0, no `out_valid`.
- Back-to-back ADDU, SUBU, AND, OR, XOR on consecutive cycles -> five consecutive `out_valid` pulses with correct results.
